// File: rtl/alu_exec_unit_if.sv
// rtl/alu_exec_unit_if.sv - start/done request bus between the operand muxes and the ALU execute unit
interface alu_exec_unit_if;
  logic        start;
  logic [3:0]  alu_operation;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  modport master (
    output start, alu_operation, a, b,
    input  busy, done, result, zero, illegal
  );

  modport slave (
    input  start, alu_operation, a, b,
    output busy, done, result, zero, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU: single-cycle logic/shift ops, 32-step shift-add multiply
module alu_exec_unit (
  input  logic               clk,
  input  logic               rst,
  alu_exec_unit_if.slave     bus
);
  typedef enum logic {IDLE, MUL} state_t;

  localparam logic [3:0] OP_MUL = 4'd2;

  state_t      state, state_next;
  logic [31:0] mcand, mcand_next;
  logic [31:0] mplier, mplier_next;
  logic [31:0] acc, acc_next;
  logic [4:0]  count, count_next;
  logic        done_q, done_next;
  logic [31:0] result_q, result_next;
  logic        zero_q, zero_next;
  logic        illegal_q, illegal_next;

  logic [31:0] single_res;
  logic        single_ill;
  logic [31:0] step_sum;

  always_comb begin
    single_res = 32'd0;
    single_ill = 1'b0;
    case (bus.alu_operation)
      4'd0:        single_res = bus.a + bus.b;
      4'd1:        single_res = bus.a - bus.b;
      4'd3, 4'd9:  single_res = bus.a << bus.b[4:0];
      4'd4:        single_res = {31'd0, $signed(bus.a) < $signed(bus.b)};
      4'd5:        single_res = bus.a ^ bus.b;
      4'd6, 4'd10: single_res = bus.a >> bus.b[4:0];
      4'd7:        single_res = bus.a | bus.b;
      4'd8:        single_res = bus.a & bus.b;
      default:     single_ill = 1'b1;
    endcase
  end

  assign step_sum = mplier[0] ? (acc + mcand) : acc;

  always_comb begin
    state_next   = state;
    mcand_next   = mcand;
    mplier_next  = mplier;
    acc_next     = acc;
    count_next   = count;
    done_next    = 1'b0;
    result_next  = result_q;
    zero_next    = zero_q;
    illegal_next = illegal_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.alu_operation == OP_MUL) begin
            mcand_next  = bus.a;
            mplier_next = bus.b;
            acc_next    = 32'd0;
            count_next  = 5'd0;
            state_next  = MUL;
          end else begin
            result_next  = single_res;
            zero_next    = (single_res == 32'd0);
            illegal_next = single_ill;
            done_next    = 1'b1;
          end
        end
      end
      MUL: begin
        acc_next    = step_sum;
        mcand_next  = mcand << 1;
        mplier_next = mplier >> 1;
        count_next  = count + 5'd1;
        // count==31 marks the 32nd step; its sum is the final product
        if (count == 5'd31) begin
          state_next   = IDLE;
          result_next  = step_sum;
          zero_next    = (step_sum == 32'd0);
          illegal_next = 1'b0;
          done_next    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mcand     <= 32'd0;
      mplier    <= 32'd0;
      acc       <= 32'd0;
      count     <= 5'd0;
      done_q    <= 1'b0;
      result_q  <= 32'd0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_next;
      mcand     <= mcand_next;
      mplier    <= mplier_next;
      acc       <= acc_next;
      count     <= count_next;
      done_q    <= done_next;
      result_q  <= result_next;
      zero_q    <= zero_next;
      illegal_q <= illegal_next;
    end
  end

  assign bus.busy    = (state == MUL);
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.zero    = zero_q;
  assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - scoreboard bench for alu_exec_unit
module tb_alu_exec_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [32:0] sb[$];

  alu_exec_unit_if bus ();

  alu_exec_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    case (op)
      4'd0:        return {1'b0, a + b};
      4'd1:        return {1'b0, a - b};
      4'd2: begin
        prod = {32'd0, a} * {32'd0, b};
        return {1'b0, prod[31:0]};
      end
      4'd3, 4'd9:  return {1'b0, a << b[4:0]};
      4'd4:        return {1'b0, 31'd0, ($signed(a) < $signed(b))};
      4'd5:        return {1'b0, a ^ b};
      4'd6, 4'd10: return {1'b0, a >> b[4:0]};
      4'd7:        return {1'b0, a | b};
      4'd8:        return {1'b0, a & b};
      default:     return {1'b1, 32'd0};
    endcase
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      check("busy_with_done", {31'd0, bus.busy}, 32'd0);
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        check("result", bus.result, e[31:0]);
        check("zero", {31'd0, bus.zero}, {31'd0, e[31:0] == 32'd0});
        check("illegal", {31'd0, bus.illegal}, {31'd0, e[32]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request (caller is 1ns after an edge), then follow it to its done pulse
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [32:0] exp);
    int extra;
    int busy_cycles;
    bus.start = 1'b1;
    bus.alu_operation = op;
    bus.a = a;
    bus.b = b;
    sb.push_back(exp);
    tick();
    bus.start = 1'b0;
    bus.a = ~a;
    bus.b = $urandom;
    bus.alu_operation = 4'd0;
    extra = 0;
    busy_cycles = 0;
    while (!bus.done && extra < 40) begin
      if (bus.busy) busy_cycles++;
      tick();
      extra++;
    end
    check("done_seen", {31'd0, bus.done}, 32'd1);
    check("latency", extra, (op == 4'd2) ? 32 : 0);
    check("busy_cycles", busy_cycles, (op == 4'd2) ? 32 : 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.alu_operation = 4'd0;
    bus.a = 32'd0;
    bus.b = 32'd0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_zero", {31'd0, bus.zero}, 32'd1);
    check("rst_illegal", {31'd0, bus.illegal}, 32'd0);

    run_op(4'd0, 32'hFFFFFFFF, 32'd1, {1'b0, 32'h00000000});
    run_op(4'd1, 32'd0, 32'd1, {1'b0, 32'hFFFFFFFF});
    run_op(4'd3, 32'd1, 32'h21, {1'b0, 32'h00000002});
    run_op(4'd6, 32'h80000000, 32'd31, {1'b0, 32'h00000001});
    run_op(4'd4, 32'hFFFFFFFF, 32'd0, {1'b0, 32'h00000001});
    run_op(4'd4, 32'd0, 32'hFFFFFFFF, {1'b0, 32'h00000000});
    run_op(4'd2, 32'h7FFFFFFF, 32'd3, {1'b0, 32'h7FFFFFFD});
    run_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, {1'b0, 32'h00000001});

    // Busy blocking: a code-0 start during multiply must be dropped
    bus.start = 1'b1;
    bus.alu_operation = 4'd2;
    bus.a = 32'd6;
    bus.b = 32'd7;
    sb.push_back({1'b0, 32'd42});
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.start = 1'b1;
    bus.alu_operation = 4'd0;
    bus.a = 32'd1;
    bus.b = 32'd1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 40 && !bus.done; i++) tick();
    check("block_done", {31'd0, bus.done}, 32'd1);
    repeat (3) tick();

    // Back-to-back: OR request lands in the mul done cycle
    bus.start = 1'b1;
    bus.alu_operation = 4'd2;
    bus.a = 32'd3;
    bus.b = 32'd5;
    sb.push_back({1'b0, 32'd15});
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 40 && !bus.done; i++) tick();
    check("b2b_mul_done", {31'd0, bus.done}, 32'd1);
    run_op(4'd7, 32'h0F0F0000, 32'h000000F0, {1'b0, 32'h0F0F00F0});

    // Reset mid-multiply: no done, result cleared
    bus.start = 1'b1;
    bus.alu_operation = 4'd2;
    bus.a = 32'h1234;
    bus.b = 32'h5678;
    tick();
    bus.start = 1'b0;
    repeat (15) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_result", bus.result, 32'd0);
    check("abort_zero", {31'd0, bus.zero}, 32'd1);
    repeat (40) tick();
    run_op(4'hC, 32'h55, 32'hAA, {1'b1, 32'd0});

    for (int i = 0; i < 10; i++) begin
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      run_op(op, a, b, model(op, a, b));
    end

    repeat (3) tick();
    check("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
